riscv_alu: RTL and testbench
============================

RISCV_ALU -- requirements
Module: riscv_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of A, B and ALUout; all requirements below use WIDTH=32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: ALUctl  input  4  operation select.
REQ-005 Port: A  input  WIDTH  first operand.
REQ-006 Port: B  input  WIDTH  second operand; B[4:0] is the shift amount.
REQ-007 Port: in_valid  input  1  operands and ALUctl are valid this cycle.
REQ-008 Port: ALUout  output  WIDTH  registered result.
REQ-009 Port: zero  output  1  registered flag, 1 when the registered ALUout is all zeros.
REQ-010 Port: out_valid  output  1  ALUout/zero hold the result of an accepted operation.

Function
REQ-011 Operation map: 0000 AND (A&B), 0001 OR (A|B), 0010 ADD (A+B, modulo 2^32), 0011 XOR, 0100 SLL (A<<B[4:0]), 0101 SRL (logical), 0110 SUB (A-B, modulo 2^32), 0111 SLT (signed two's-complement A<B gives 1, else 0), 1000 SLTU (unsigned A<B gives 1, else 0), 1001 SRA (arithmetic, sign-filled), 1100 NOR (~(A|B)).
REQ-012 Every unlisted ALUctl code shall produce result 0 (and therefore zero=1); no error flag.
REQ-013 ADD/SUB overflow and carry are discarded; no overflow output.
REQ-014 SLT/SLTU results are zero-extended to WIDTH bits (only bit 0 may be 1).
REQ-015 Shift amounts use only B[4:0]; B[31:5] are ignored; shift by 0 returns A unchanged.
REQ-016 Latency: exactly one clock; when in_valid=1 at edge N, ALUout/zero reflect those inputs and out_valid=1 after edge N.
REQ-017 When in_valid=0 at an edge, ALUout and zero hold their previous values and out_valid goes to 0.
REQ-018 zero shall be computed from the same-cycle combinational result and registered with ALUout, so both are always consistent.
REQ-019 Back-to-back operations (in_valid=1 every cycle) shall be accepted at full throughput, one result per cycle, no stalls.

Reset
REQ-020 When reset=1 at a rising edge: ALUout=0, zero=1, out_valid=0, regardless of in_valid.
REQ-021 Reset has priority over a simultaneous in_valid; an operation presented during reset is discarded.
REQ-022 Reset asserted mid-stream clears state on that edge; first result after deassertion comes from in_valid sampled on the first edge with reset=0.

Structure
REQ-023 A shared package shall hold the 4-bit ALUctl opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_NOR) and the WIDTH default.
REQ-024 One sub-module is natural: riscv_alu_core, purely combinational (ALUctl, A, B -> result, zero_comb); riscv_alu adds the output register stage and valid tracking.
REQ-025 No latches; combinational case statement must have a default assignment.

Verification
REQ-026 AND: A=0x0000000F, B=0x0000000A, ALUctl=0000, in_valid=1 -> next cycle ALUout=0x0000000A, zero=0, out_valid=1.
REQ-027 OR/NOR: A=0x00000000, B=0x0000000A; ALUctl=0001 -> 0x0000000A, zero=0; ALUctl=1100 -> 0xFFFFFFF5, zero=0.
REQ-028 ADD/SUB: A=9, B=1, ALUctl=0010 -> 10; A=8, B=2, ALUctl=0110 -> 6; A=5, B=5, ALUctl=0110 -> 0, zero=1; A=0xFFFFFFFF, B=1, ADD -> 0, zero=1.
REQ-029 SLT/SLTU: A=8, B=9, 0111 -> 1, zero=0; A=0xA, B=9, 0111 -> 0, zero=1; A=0xFFFFFFFF, B=1: 0111 -> 1, 1000 -> 0.
REQ-030 Shifts: A=0x80000000, B=0x00000024 (shamt 4): SRL -> 0x08000000, SRA -> 0xF8000000, SLL -> 0x00000000 with zero=1.
REQ-031 Control: reset=1 with in_valid=1 -> ALUout=0, zero=1, out_valid=0; in_valid=0 after a result -> ALUout held, out_valid=0; unlisted code 1111 -> ALUout=0, zero=1.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared constants for the RISC-V style ALU: default datapath width and
// the 4-bit ALUctl operation codes.
package riscv_alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/riscv_alu_core.sv
// Purely combinational ALU datapath: operation select, result and the
// all-zeros flag derived from that same result.
module riscv_alu_core
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero_comb
);

  logic [4:0] shamt_s;
  logic       lt_signed_s;
  logic       lt_unsigned_s;

  assign shamt_s       = B[4:0];
  assign lt_signed_s   = $signed(A) < $signed(B);
  assign lt_unsigned_s = A < B;

  // Operation select; unlisted codes fall through to an all-zeros result
  always_comb begin
    result = {WIDTH{1'b0}};
    case (ALUctl)
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_ADD:  result = A + B;
      ALU_XOR:  result = A ^ B;
      ALU_SLL:  result = A << shamt_s;
      ALU_SRL:  result = A >> shamt_s;
      ALU_SUB:  result = A - B;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed_s};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned_s};
      ALU_SRA:  result = $unsigned($signed(A) >>> shamt_s);
      ALU_NOR:  result = ~(A | B);
      default:  result = {WIDTH{1'b0}};
    endcase
  end

  assign zero_comb = (result == {WIDTH{1'b0}});

endmodule

// File: rtl/riscv_alu.sv
// ALU top: wraps the combinational core with a one-cycle output register
// stage and result-valid tracking; results hold while no operation arrives.
module riscv_alu
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ALUout,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] result_s;
  logic             zero_comb_s;
  logic [WIDTH-1:0] alu_out_r;
  logic             zero_r;
  logic             out_valid_r;

  riscv_alu_core #(.WIDTH(WIDTH)) u_core (
    .ALUctl    (ALUctl),
    .A         (A),
    .B         (B),
    .result    (result_s),
    .zero_comb (zero_comb_s)
  );

  // Output register stage; reset wins over a simultaneous operation
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_r   <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      alu_out_r   <= result_s;
      zero_r      <= zero_comb_s;
      out_valid_r <= 1'b1;
    end else begin
      alu_out_r   <= alu_out_r;
      zero_r      <= zero_r;
      out_valid_r <= 1'b0;
    end
  end

  assign ALUout    = alu_out_r;
  assign zero      = zero_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed vector table, control corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_riscv_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic        in_valid;
  logic [31:0] ALUout;
  logic        zero;
  logic        out_valid;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  riscv_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUctl    (ALUctl),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .ALUout    (ALUout),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model from the operation rules, using plain arithmetic
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] pow2;
    sh   = b % 32;
    pow2 = 32'd1 << sh;
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a * pow2;
      4'd5:  return a / pow2;
      4'd6:  return a + (~b + 32'd1);
      4'd7:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return a[31] ? ~((~a) / pow2) : a / pow2;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    ALUctl   = c;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [31:0] eo, input logic ez, input logic ev);
    check({name, "_out"},   ALUout,           eo);
    check({name, "_zero"},  {31'd0, zero},     {31'd0, ez});
    check({name, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  logic [31:0] exp_out;
  logic        exp_zero;
  logic        exp_valid;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    ALUctl   = 4'd0;
    A        = 32'd0;
    B        = 32'd0;

    vecs.push_back('{4'b0000, 32'h0000_000F, 32'h0000_000A, 32'h0000_000A, 1'b0});
    vecs.push_back('{4'b0001, 32'h0000_0000, 32'h0000_000A, 32'h0000_000A, 1'b0});
    vecs.push_back('{4'b1100, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFF5, 1'b0});
    vecs.push_back('{4'b0010, 32'd9,         32'd1,         32'd10,        1'b0});
    vecs.push_back('{4'b0110, 32'd8,         32'd2,         32'd6,         1'b0});
    vecs.push_back('{4'b0110, 32'd5,         32'd5,         32'd0,         1'b1});
    vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1});
    vecs.push_back('{4'b0111, 32'd8,         32'd9,         32'd1,         1'b0});
    vecs.push_back('{4'b0111, 32'h0000_000A, 32'd9,         32'd0,         1'b1});
    vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0});
    vecs.push_back('{4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1});
    vecs.push_back('{4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0});
    vecs.push_back('{4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
    vecs.push_back('{4'b0100, 32'h8000_0000, 32'h0000_0024, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0});
    vecs.push_back('{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'b0100, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0});
    vecs.push_back('{4'b1001, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b1});
    vecs.push_back('{4'b1001, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0});

    // reset with a simultaneous operation is discarded
    step(1'b1, 1'b1, 4'b0010, 32'd3, 32'd4);
    step(1'b1, 1'b1, 4'b0010, 32'd3, 32'd4);
    check_out("reset", 32'd0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].ctl, vecs[i].a, vecs[i].b);
      check_out($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_zero, 1'b1);
    end

    // idle cycle holds the last result and drops valid
    step(1'b0, 1'b1, 4'b0010, 32'd100, 32'd23);
    step(1'b0, 1'b0, 4'b0010, 32'd1, 32'd1);
    check_out("hold", 32'd123, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 32'd0, 32'd0);
    check_out("hold2", 32'd123, 1'b0, 1'b0);

    // mid-stream reset, then the first edge after deassertion is accepted
    step(1'b0, 1'b1, 4'b0001, 32'h00FF_0000, 32'h0000_00FF);
    check_out("pre_rst", 32'h00FF_00FF, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b0001, 32'h1111_1111, 32'h2222_2222);
    check_out("mid_rst", 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0110, 32'd7, 32'd9);
    check_out("post_rst", 32'hFFFF_FFFE, 1'b0, 1'b1);

    exp_out   = 32'hFFFF_FFFE;
    exp_zero  = 1'b0;
    exp_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic        r_rst;
      logic        r_v;
      logic [3:0]  r_c;
      logic [31:0] r_a;
      logic [31:0] r_b;
      r_rst = ($urandom_range(0, 29) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_c   = 4'($urandom_range(0, 15));
      r_a   = $urandom;
      r_b   = $urandom;
      case ($urandom_range(0, 5))
        0: r_b = r_a;
        1: r_a = {r_a[31], 31'd0};
        2: r_b = 32'($urandom_range(0, 40));
        default: r_a = r_a;
      endcase
      step(r_rst, r_v, r_c, r_a, r_b);
      if (r_rst) begin
        exp_out   = 32'd0;
        exp_zero  = 1'b1;
        exp_valid = 1'b0;
      end else if (r_v) begin
        exp_out   = model(r_c, r_a, r_b);
        exp_zero  = (exp_out == 32'd0);
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      check_out($sformatf("rnd%0d_op%0d", n, r_c), exp_out, exp_zero, exp_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
